// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sequencer: opcode encodings, per-opcode
// latencies and the small decode helpers used at request acceptance.
package fpu_pkg;

    localparam logic [3:0] FADD  = 4'd1;
    localparam logic [3:0] FSUB  = 4'd2;
    localparam logic [3:0] FMUL  = 4'd3;
    localparam logic [3:0] FDIV  = 4'd4;
    localparam logic [3:0] FSQRT = 4'd5;
    localparam logic [3:0] FEQ   = 4'd6;
    localparam logic [3:0] FLT   = 4'd7;
    localparam logic [3:0] FLE   = 4'd8;
    localparam logic [3:0] FTOI  = 4'd9;
    localparam logic [3:0] ITOF  = 4'd10;
    localparam logic [3:0] FMOV0 = 4'd11;
    localparam logic [3:0] FMOV1 = 4'd12;
    localparam logic [3:0] FMOV2 = 4'd13;
    localparam logic [3:0] FLUP  = 4'd14;

    // Latencies in cycles; each must stay within 1..8 to fit the 3-bit counter.
    localparam int unsigned LAT_ADD  = 2;
    localparam int unsigned LAT_MUL  = 2;
    localparam int unsigned LAT_DIV  = 4;
    localparam int unsigned LAT_SQRT = 4;
    localparam int unsigned LAT_CVT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] op_latency(input logic [3:0] ctrl);
        logic [3:0] lat;
        case (ctrl)
            FADD, FSUB:  lat = 4'(LAT_ADD);
            FMUL:        lat = 4'(LAT_MUL);
            FDIV:        lat = 4'(LAT_DIV);
            FSQRT:       lat = 4'(LAT_SQRT);
            FTOI, ITOF:  lat = 4'(LAT_CVT);
            default:     lat = 4'd1;
        endcase
        return lat;
    endfunction

    function automatic logic is_nop(input logic [3:0] ctrl);
        return (ctrl == 4'd0) || (ctrl == 4'd15);
    endfunction

endpackage

// File: rtl/fpu_seq.sv
// Sequencing front end for the combinational FPU: holds operands stable for the
// opcode latency, then parks the result in a one-entry writeback buffer.
module fpu_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_ctrl,
    input  logic [31:0] req_ds_val,
    input  logic [31:0] req_dt_val,
    input  logic [5:0]  req_dd,
    input  logic [15:0] req_imm,
    output logic [3:0]  fpu_ctrl,
    output logic [31:0] fpu_ds_val,
    output logic [31:0] fpu_dt_val,
    output logic [5:0]  fpu_dd,
    output logic [15:0] fpu_imm,
    input  logic [5:0]  fpu_reg_addr,
    input  logic [31:0] fpu_dd_val,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [5:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [5:0]  pend_dd
);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [3:0]  ctrl_q;
    logic [31:0] ds_q;
    logic [31:0] dt_q;
    logic [5:0]  dd_q;
    logic [15:0] imm_q;
    logic        wb_valid_q;
    logic [5:0]  wb_addr_q;
    logic [31:0] wb_data_q;

    logic        ready_s;
    logic        load_s;
    logic [3:0]  lat_s;
    logic [2:0]  cnt_d;
    logic [5:0]  pend_s;

    // Handshake decode: ready is forced low while reset is held.
    always_comb begin
        ready_s = 1'b0;
        pend_s  = 6'd0;
        case (state_q)
            ST_IDLE: ready_s = 1'b1;
            ST_EXEC: pend_s  = dd_q;
            ST_DONE: begin
                ready_s = wb_ready;
                pend_s  = wb_addr_q;
            end
            default: ready_s = 1'b0;
        endcase
        if (!rstn) begin
            ready_s = 1'b0;
        end else begin
            ready_s = ready_s;
        end
        load_s = req_valid && ready_s && !is_nop(req_ctrl);
        lat_s  = op_latency(req_ctrl);
        cnt_d  = 3'(lat_s - 4'd1);
    end

    // Sequencer FSM with operand registers and the writeback buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            ctrl_q     <= 4'd0;
            ds_q       <= 32'd0;
            dt_q       <= 32'd0;
            dd_q       <= 6'd0;
            imm_q      <= 16'd0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 6'd0;
            wb_data_q  <= 32'd0;
        end else begin
            if (load_s) begin
                ctrl_q <= req_ctrl;
                ds_q   <= req_ds_val;
                dt_q   <= req_dt_val;
                dd_q   <= req_dd;
                imm_q  <= req_imm;
                cnt_q  <= cnt_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load_s) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 3'd0) begin
                        wb_data_q  <= fpu_dd_val;
                        wb_addr_q  <= fpu_reg_addr;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    // A taken writeback may overlap the next accept for bubble-free issue.
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= load_s ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = ready_s;
    assign fpu_ctrl   = ctrl_q;
    assign fpu_ds_val = ds_q;
    assign fpu_dt_val = dt_q;
    assign fpu_dd     = dd_q;
    assign fpu_imm    = imm_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign pend_dd    = pend_s;

endmodule
